// File: rtl/usr_serial_rx.sv
// usr_serial_rx: deserialiser for the USR serial output path.
// Collects WIDTH bits, either LSB-first or MSB-first, into a word. The word
// is presented on a registered parallel output with a valid/ready handshake.
// A word that completes while the output is still held is dropped, and the
// sticky overrun flag records the loss.
module usr_serial_rx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             SI,
    input  logic             dir,
    input  logic             clr,
    input  logic             ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] par_out,
    output logic             valid,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] asm_q,     asm_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dir_lat_q, dir_lat_d;
    logic [WIDTH-1:0] par_q,     par_d;
    logic             valid_q,   valid_d;
    logic             ovr_q,     ovr_d;

    // Bit order for the incoming bit. The first bit of a word uses the live
    // dir, because dir is latched on that same edge.
    logic             use_dir;
    logic [WIDTH-1:0] asm_shifted;
    logic             word_done;

    // Place the incoming bit according to the effective bit order.
    always_comb begin
        use_dir     = (state_q == IDLE) ? dir : dir_lat_q;
        asm_shifted = use_dir ? {asm_q[WIDTH-2:0], SI}
                              : {SI, asm_q[WIDTH-1:1]};
    end

    // Next-state logic for the assembler FSM, the output register and the flags.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d   = state_q;
        asm_d     = asm_q;
        bit_cnt_d = bit_cnt_q;
        dir_lat_d = dir_lat_q;
        par_d     = par_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q & ~ovr_clr;
        word_done = 1'b0;

        // A held word is consumed here. A completion later in this block
        // may set valid again.
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (clr) begin
            // Abort dominates the bit strobe. The output side is untouched.
            asm_d     = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
        end else if (en) begin
            asm_d = asm_shifted;
            unique case (state_q)
                IDLE: begin
                    dir_lat_d = dir;
                    bit_cnt_d = CNT_W'(1);
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (word_done) begin
            if (!valid_q || ready) begin
                par_d   = asm_shifted;
                valid_d = 1'b1;
            end else begin
                // The output is still held: drop the new word. Setting the flag
                // takes priority over ovr_clr on the same edge.
                ovr_d = 1'b1;
            end
        end
    end

    // State registers with an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            asm_q     <= '0;
            bit_cnt_q <= '0;
            dir_lat_q <= 1'b0;
            par_q     <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples
            // the pre-edge values.
            state_q   <= state_d;
            asm_q     <= asm_d;
            bit_cnt_q <= bit_cnt_d;
            dir_lat_q <= dir_lat_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign par_out = par_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;
    assign busy    = (state_q == SHIFT);
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_usr_serial_rx.sv
// Testbench for usr_serial_rx. Part 1 applies a table of directed vectors
// with hand-computed expectations. Part 2 is a reset applied mid-word.
// Part 3 is random traffic compared against a word-level model.
module tb_usr_serial_rx;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rstb, en, si, dir, clr, ready, ovr_clr;
    logic [WIDTH-1:0] par_out;
    logic             valid, overrun, busy;
    logic [CNT_W-1:0] bit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    usr_serial_rx #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rstb    (rstb),
        .en      (en),
        .SI      (si),
        .dir     (dir),
        .clr     (clr),
        .ready   (ready),
        .ovr_clr (ovr_clr),
        .par_out (par_out),
        .valid   (valid),
        .overrun (overrun),
        .busy    (busy),
        .bit_cnt (bit_cnt)
    );

    always #5 clk = ~clk;

    // Word-level reference model. The partial word is held as a list of
    // received bits, and a word is built only once WIDTH bits have arrived.
    logic             m_bits[$];
    logic             m_dir;
    logic [WIDTH-1:0] m_par;
    logic             m_valid;
    logic             m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_par   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Apply one rising edge to the model using the current inputs.
    task automatic model_edge();
        logic [WIDTH-1:0] word;
        logic             nvalid;
        logic             novr;
        nvalid = (m_valid && ready) ? 1'b0 : m_valid;
        novr   = m_ovr && !ovr_clr;
        if (clr) begin
            m_bits.delete();
        end else if (en) begin
            if (m_bits.size() == 0) m_dir = dir;
            m_bits.push_back(si);
            if (m_bits.size() == WIDTH) begin
                word = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (m_dir) word[WIDTH-1-i] = m_bits[i];
                    else       word[i]         = m_bits[i];
                end
                m_bits.delete();
                if (!m_valid || ready) begin
                    m_par  = word;
                    nvalid = 1'b1;
                end else begin
                    novr = 1'b1;
                end
            end
        end
        m_valid = nvalid;
        m_ovr   = novr;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".par_out"}, 32'(par_out), 32'(m_par));
        check({tag, ".valid"},   32'(valid),   32'(m_valid));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(m_bits.size()));
        check({tag, ".busy"},    32'(busy),    32'(m_bits.size() != 0));
    endtask

    task automatic set_in(input logic e, input logic s, input logic d,
                          input logic c, input logic r, input logic oc);
        en = e; si = s; dir = d; clr = c; ready = r; ovr_clr = oc;
    endtask

    // One clock: the model follows the edge and outputs are sampled 1 ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic             en, si, dir, clr, ready, ovr_clr;
        logic [WIDTH-1:0] par;
        logic             valid, ovr;
        int               cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic e, input logic s, input logic d, input logic c,
                        input logic r, input logic oc, input logic [WIDTH-1:0] p,
                        input logic v, input logic o, input int n);
        vec_t t;
        t.en = e; t.si = s; t.dir = d; t.clr = c; t.ready = r; t.ovr_clr = oc;
        t.par = p; t.valid = v; t.ovr = o; t.cnt = n;
        vecs.push_back(t);
    endtask

    initial begin
        rstb = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();

        //    en si dir clr rdy oc | par  val ovr cnt
        // Word dir=0 with bits 1,0,1,1 gives 4'hD, then it is consumed.
        addv(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 1);
        addv(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 2);
        addv(1, 1, 0, 0, 0, 0, 4'h0, 0, 0, 3);
        addv(1, 1, 0, 0, 0, 0, 4'hD, 1, 0, 0);
        addv(0, 0, 0, 0, 1, 0, 4'hD, 0, 0, 0);
        // Word dir=1 with bits 1,0,1,1 gives 4'hB. dir drops after the first bit.
        addv(1, 1, 1, 0, 0, 0, 4'hD, 0, 0, 1);
        addv(1, 0, 0, 0, 0, 0, 4'hD, 0, 0, 2);
        addv(1, 1, 0, 0, 0, 0, 4'hD, 0, 0, 3);
        addv(1, 1, 0, 0, 0, 0, 4'hB, 1, 0, 0);
        addv(0, 0, 0, 0, 1, 0, 4'hB, 0, 0, 0);
        // Overrun: 4'hD is held, then 4'h5 arrives and is dropped. ovr_clr follows.
        addv(1, 1, 0, 0, 0, 0, 4'hB, 0, 0, 1);
        addv(1, 0, 0, 0, 0, 0, 4'hB, 0, 0, 2);
        addv(1, 1, 0, 0, 0, 0, 4'hB, 0, 0, 3);
        addv(1, 1, 0, 0, 0, 0, 4'hD, 1, 0, 0);
        addv(1, 1, 0, 0, 0, 0, 4'hD, 1, 0, 1);
        addv(1, 0, 0, 0, 0, 0, 4'hD, 1, 0, 2);
        addv(1, 1, 0, 0, 0, 0, 4'hD, 1, 0, 3);
        addv(1, 0, 0, 0, 0, 0, 4'hD, 1, 1, 0);
        addv(0, 0, 0, 0, 0, 1, 4'hD, 1, 0, 0);
        // Consume on the same edge that 4'h6 (bits 0,1,1,0) completes.
        addv(1, 0, 0, 0, 0, 0, 4'hD, 1, 0, 1);
        addv(1, 1, 0, 0, 0, 0, 4'hD, 1, 0, 2);
        addv(1, 1, 0, 0, 0, 0, 4'hD, 1, 0, 3);
        addv(1, 0, 0, 0, 1, 0, 4'h6, 1, 0, 0);
        // Bits 1,1 with a three-cycle gap, then clr with en=1. valid is held.
        addv(1, 1, 0, 0, 0, 0, 4'h6, 1, 0, 1);
        addv(0, 0, 0, 0, 0, 0, 4'h6, 1, 0, 1);
        addv(0, 0, 0, 0, 0, 0, 4'h6, 1, 0, 1);
        addv(0, 0, 0, 0, 0, 0, 4'h6, 1, 0, 1);
        addv(1, 1, 0, 0, 0, 0, 4'h6, 1, 0, 2);
        addv(1, 1, 0, 1, 0, 0, 4'h6, 1, 0, 0);
        addv(0, 0, 0, 0, 1, 0, 4'h6, 0, 0, 0);
        // A fresh word after clr: bits 0,1,1,0 give 4'h6.
        addv(1, 0, 0, 0, 0, 0, 4'h6, 0, 0, 1);
        addv(1, 1, 0, 0, 0, 0, 4'h6, 0, 0, 2);
        addv(1, 1, 0, 0, 0, 0, 4'h6, 0, 0, 3);
        addv(1, 0, 0, 0, 0, 0, 4'h6, 1, 0, 0);

        // Reset state.
        #12;
        check("reset.par_out", 32'(par_out), 32'h0);
        check("reset.valid",   32'(valid),   32'h0);
        check("reset.overrun", 32'(overrun), 32'h0);
        check("reset.bit_cnt", 32'(bit_cnt), 32'h0);
        check("reset.busy",    32'(busy),    32'h0);
        @(negedge clk);
        rstb = 1'b1;

        // Part 1: directed table.
        foreach (vecs[i]) begin
            set_in(vecs[i].en, vecs[i].si, vecs[i].dir, vecs[i].clr,
                   vecs[i].ready, vecs[i].ovr_clr);
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_par", i),   32'(par_out), 32'(vecs[i].par));
            check($sformatf("vec%0d.tbl_valid", i), 32'(valid),   32'(vecs[i].valid));
            check($sformatf("vec%0d.tbl_ovr", i),   32'(overrun), 32'(vecs[i].ovr));
            check($sformatf("vec%0d.tbl_cnt", i),   32'(bit_cnt), 32'(vecs[i].cnt));
            check($sformatf("vec%0d.tbl_busy", i),  32'(busy),    32'(vecs[i].cnt != 0));
        end

        // Part 2: asynchronous reset after two bits of a word.
        set_in(1, 1, 0, 0, 0, 0); tick("rst_pre0");
        set_in(1, 0, 0, 0, 0, 0); tick("rst_pre1");
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        rstb = 1'b0;
        #1;
        model_reset();
        check("midrst.par_out", 32'(par_out), 32'h0);
        check("midrst.valid",   32'(valid),   32'h0);
        check("midrst.overrun", 32'(overrun), 32'h0);
        check("midrst.bit_cnt", 32'(bit_cnt), 32'h0);
        check("midrst.busy",    32'(busy),    32'h0);
        @(negedge clk);
        rstb = 1'b1;
        set_in(1, 1, 0, 0, 0, 0); tick("post_rst0");
        set_in(1, 1, 0, 0, 0, 0); tick("post_rst1");
        set_in(1, 0, 0, 0, 0, 0); tick("post_rst2");
        set_in(1, 0, 0, 0, 0, 0); tick("post_rst3");
        check("post_rst.word",  32'(par_out), 32'h3);
        check("post_rst.valid", 32'(valid),   32'h1);

        // Part 3: random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4),
                   ($urandom_range(0, 9) == 0));
            tick($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
